sample_delay: RTL and testbench

//  Circular-buffer sample delay: writes one 8-bit sample per en strobe into an

---
 rtl/sample_delay.sv | 114 +++++++++++
 tb/tb_sample_delay.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_delay.sv
// Circular-buffer sample delay: stores one sample per strobe and returns the one written `offset` strobes earlier.
// Optional build macro SAMPLE_DELAY_PEAK_EN adds a running peak detector (peak_clr / peak ports).
module sample_delay #(
  parameter int unsigned A_WIDTH = 9,
  parameter int unsigned D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [A_WIDTH-1:0] offset,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               rd_valid,
  output logic               primed
`ifdef SAMPLE_DELAY_PEAK_EN
  ,
  input  logic               peak_clr,
  output logic [D_WIDTH-1:0] peak
`endif
);

  localparam int unsigned DEPTH = 1 << A_WIDTH;
  localparam logic [A_WIDTH-1:0] FILL_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t             state;
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] fill;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [D_WIDTH-1:0] ram [DEPTH];

  assign rd_ptr = wr_ptr - offset;
  assign primed = (fill >= offset);

  // Sample storage; contents survive reset, the primed gate keeps stale data hidden.
  always_ff @(posedge clk) begin
    if (en) begin
      ram[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
    end else if (en) begin
      wr_ptr <= wr_ptr + A_WIDTH'(1);
    end
  end

  // Fill tracking: counts strobes and saturates once the buffer has been filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      fill  <= '0;
    end else if (en) begin
      case (state)
        EMPTY: begin
          fill  <= A_WIDTH'(1);
          state <= FILLING;
        end
        FILLING: begin
          fill <= fill + A_WIDTH'(1);
          if (fill == FILL_MAX - A_WIDTH'(1)) begin
            state <= FULL;
          end
        end
        FULL: begin
          fill <= FILL_MAX;
        end
        default: begin
          state <= EMPTY;
          fill  <= '0;
        end
      endcase
    end
  end

  // offset=0 bypasses the RAM so the current sample is returned (write-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= en & primed;
      if (en) begin
        if (!primed) begin
          rd_data <= '0;
        end else if (offset == '0) begin
          rd_data <= wr_data;
        end else begin
          rd_data <= ram[rd_ptr];
        end
      end
    end
  end

`ifdef SAMPLE_DELAY_PEAK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak <= '0;
    end else if (peak_clr) begin
      peak <= en ? wr_data : '0;
    end else if (en && (wr_data > peak)) begin
      peak <= wr_data;
    end
  end
`endif

endmodule

// File: tb/tb_sample_delay.sv
// Randomized scoreboard bench for sample_delay against a history-array reference model.
module tb_sample_delay;

  localparam int unsigned A_WIDTH = 9;
  localparam int unsigned D_WIDTH = 8;
  localparam int FILL_MAX = (1 << A_WIDTH) - 1;

  logic               clk;
  logic               rst;
  logic               en;
  logic [D_WIDTH-1:0] wr_data;
  logic [A_WIDTH-1:0] offset;
  logic [D_WIDTH-1:0] rd_data;
  logic               rd_valid;
  logic               primed;
`ifdef SAMPLE_DELAY_PEAK_EN
  logic               peak_clr;
  logic [D_WIDTH-1:0] peak;
  int                 peak_model;
`endif

  sample_delay #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wr_data  (wr_data),
    .offset   (offset),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .primed   (primed)
`ifdef SAMPLE_DELAY_PEAK_EN
    ,
    .peak_clr (peak_clr),
    .peak     (peak)
`endif
  );

  typedef struct {
    int                 due;
    logic               v;
    logic [D_WIDTH-1:0] d;
  } exp_t;

  exp_t q[$];
  int   hist[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [D_WIDTH-1:0] last_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: pops the expected response due this cycle, otherwise output must be idle and holding.
  always @(negedge clk) begin
    if (!rst) begin
      last_data = '0;
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        exp_t s;
        s = q.pop_front();
        checks++; errors++;
        $display("FAIL stale_expect due=%0d now=%0d", s.due, cyc);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (rd_valid !== e.v || rd_data !== e.d) begin
          errors++;
          $display("FAIL rd_out cyc=%0d got v=%0b d=%02h want v=%0b d=%02h",
                   cyc, rd_valid, rd_data, e.v, e.d);
        end
        last_data = e.d;
      end else begin
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== last_data) begin
          errors++;
          $display("FAIL idle_hold cyc=%0d got v=%0b d=%02h want v=0 d=%02h",
                   cyc, rd_valid, rd_data, last_data);
        end
      end
    end
  end

  function automatic int fill_of();
    return (hist.size() > FILL_MAX) ? FILL_MAX : hist.size();
  endfunction

  task automatic strobe(input logic [D_WIDTH-1:0] d, input int off);
    exp_t e;
    int   n;
    bit   prim;
    @(posedge clk); #1;
`ifdef SAMPLE_DELAY_PEAK_EN
    checks++;
    if (peak !== D_WIDTH'(peak_model)) begin
      errors++;
      $display("FAIL peak got %02h want %02h", peak, peak_model);
    end
`endif
    en = 1'b1;
    wr_data = d;
    offset = A_WIDTH'(off);
    #1;
    prim = (fill_of() >= off);
    checks++;
    if (primed !== prim) begin
      errors++;
      $display("FAIL primed n=%0d off=%0d got %0b want %0b", hist.size(), off, primed, prim);
    end
    n = hist.size();
    hist.push_back(int'(d));
    e.due = cyc + 1;
    e.v = prim;
    e.d = prim ? D_WIDTH'(hist[n - off]) : '0;
    q.push_back(e);
`ifdef SAMPLE_DELAY_PEAK_EN
    if (peak_clr) peak_model = int'(d);
    else if (int'(d) > peak_model) peak_model = int'(d);
`endif
  endtask

  task automatic idle();
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic drain();
    int k;
    idle();
    k = 0;
    while (q.size() > 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d", q.size());
      q.delete();
    end
  endtask

  // Mid-stream reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    idle();
    @(negedge clk); #1;
    offset = A_WIDTH'(9);
    rst = 1'b0;
    #1;
    checks++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || primed !== 1'b0) begin
      errors++;
      $display("FAIL reset_clear got d=%02h v=%0b p=%0b want 00 0 0", rd_data, rd_valid, primed);
    end
    q.delete();
    hist.delete();
`ifdef SAMPLE_DELAY_PEAK_EN
    peak_model = 0;
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    wr_data = '0;
    offset = '0;
`ifdef SAMPLE_DELAY_PEAK_EN
    peak_clr = 1'b0;
    peak_model = 0;
`endif
    #3 do_reset();

    // Write-first with zero offset, then a strobe following reset
    strobe(8'hA5, 0);
    strobe(8'h3C, 1);
    drain();
    do_reset();

    // offset=4, data=k
    for (int k = 1; k <= 10; k++) strobe(D_WIDTH'(k), 4);
    drain();
    do_reset();

    // Wrap and saturation with offset=3
    for (int k = 1; k <= 600; k++) strobe(D_WIDTH'(k), 3);
    drain();
    do_reset();

    // Offset change 2 -> 8 mid-stream
    for (int k = 1; k <= 5; k++) strobe(D_WIDTH'(k + 20), 2);
    for (int k = 6; k <= 16; k++) strobe(D_WIDTH'(k + 20), 8);
    drain();

    // Random stream with gaps and offset changes, then a mid-stream reset
    for (int k = 0; k < 700; k++) begin
      int off;
      if ($urandom_range(3, 0) == 0) idle();
      case ($urandom_range(3, 0))
        0: off = 0;
        1: off = int'($urandom_range(8, 1));
        2: off = int'($urandom_range(FILL_MAX, 0));
        default: off = FILL_MAX;
      endcase
      strobe(D_WIDTH'($urandom), off);
    end
    strobe(8'h11, 0);
    do_reset();
    strobe(8'h5A, 0);
    drain();

`ifdef SAMPLE_DELAY_PEAK_EN
    do_reset();
    strobe(8'd10, 0);
    strobe(8'd200, 0);
    strobe(8'd50, 0);
    peak_clr = 1'b1;
    strobe(8'd7, 0);
    peak_clr = 1'b0;
    strobe(8'd3, 0);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
